burst_ram_arbiter: RTL and testbench

BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

---
 rtl/burst_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a burst RAM: one 64-bit burst of BURST_COUNT beats at a time.
// Optional grant statistics counters are enabled by defining BURST_RAM_ARBITER_STATS_EN.
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_cmd,
    input  logic                      a_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] a_addr,
    input  logic [63:0]               a_wr_data,
    input  logic [7:0]                a_data_mask,
    output logic [63:0]               a_rd_data,
    output logic                      a_rd_data_valid,
    output logic                      a_busy,
    input  logic                      b_cmd,
    input  logic                      b_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] b_addr,
    input  logic [63:0]               b_wr_data,
    input  logic [7:0]                b_data_mask,
    output logic [63:0]               b_rd_data,
    output logic                      b_rd_data_valid,
    output logic                      b_busy,
    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]               br_wr_data,
    output logic [7:0]                br_data_mask,
    input  logic [63:0]               br_rd_data,
    input  logic                      br_rd_data_valid,
    input  logic                      br_busy
`ifdef BURST_RAM_ARBITER_STATS_EN
    ,
    output logic [31:0]               a_grants,
    output logic [31:0]               b_grants
`endif
);

    localparam int CNT_W = $clog2(BURST_COUNT) + 1;
    // The accept cycle carries write beat 0, so WRITE itself only sees BURST_COUNT-1 beats.
    localparam logic [CNT_W-1:0] LAST_WR_CNT = CNT_W'(BURST_COUNT - 2);
    localparam logic [CNT_W-1:0] LAST_RD_CNT = CNT_W'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [CNT_W-1:0] beat_cnt_nxt_s;
    logic             last_b_r;
    logic             last_b_nxt_s;
    logic             owner_b_r;
    logic             owner_b_nxt_s;
    logic             grant_a_s;
    logic             grant_b_s;
    logic             win_cmd_s;

    // State, beat counter, owner and round-robin history registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            beat_cnt_r <= '0;
            last_b_r   <= 1'b1;
            owner_b_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            last_b_r   <= last_b_nxt_s;
            owner_b_r  <= owner_b_nxt_s;
        end
    end

    // Arbitration, next-state logic and RAM-side / read-valid routing
    always_comb begin
        state_nxt_s     = state_r;
        beat_cnt_nxt_s  = beat_cnt_r;
        last_b_nxt_s    = last_b_r;
        owner_b_nxt_s   = owner_b_r;
        grant_a_s       = 1'b0;
        grant_b_s       = 1'b0;
        win_cmd_s       = 1'b0;
        br_cmd          = 1'b0;
        br_cmd_en       = 1'b0;
        br_addr         = '0;
        br_wr_data      = 64'd0;
        br_data_mask    = 8'd0;
        a_rd_data_valid = 1'b0;
        b_rd_data_valid = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst_n && !br_busy) begin
                    if (a_cmd_en && (!b_cmd_en || last_b_r)) begin
                        grant_a_s = 1'b1;
                    end else begin
                        grant_b_s = b_cmd_en;
                    end
                end else begin
                    grant_a_s = 1'b0;
                    grant_b_s = 1'b0;
                end
                if (grant_a_s || grant_b_s) begin
                    win_cmd_s      = grant_b_s ? b_cmd : a_cmd;
                    br_cmd_en      = 1'b1;
                    br_cmd         = win_cmd_s;
                    br_addr        = grant_b_s ? b_addr : a_addr;
                    br_wr_data     = grant_b_s ? b_wr_data : a_wr_data;
                    br_data_mask   = grant_b_s ? b_data_mask : a_data_mask;
                    owner_b_nxt_s  = grant_b_s;
                    last_b_nxt_s   = grant_b_s;
                    beat_cnt_nxt_s = '0;
                    state_nxt_s    = win_cmd_s ? WRITE : READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                br_wr_data   = owner_b_r ? b_wr_data : a_wr_data;
                br_data_mask = owner_b_r ? b_data_mask : a_data_mask;
                if (beat_cnt_r == LAST_WR_CNT) begin
                    state_nxt_s    = IDLE;
                    beat_cnt_nxt_s = '0;
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                end
            end
            READ: begin
                if (br_rd_data_valid) begin
                    a_rd_data_valid = rst_n && !owner_b_r;
                    b_rd_data_valid = rst_n && owner_b_r;
                    if (beat_cnt_r == LAST_RD_CNT) begin
                        state_nxt_s    = IDLE;
                        beat_cnt_nxt_s = '0;
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                    end
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                beat_cnt_nxt_s = '0;
            end
        endcase
    end

    assign a_busy    = !rst_n || (state_r != IDLE) || br_busy || grant_b_s;
    assign b_busy    = !rst_n || (state_r != IDLE) || br_busy || grant_a_s;
    assign a_rd_data = br_rd_data;
    assign b_rd_data = br_rd_data;

`ifdef BURST_RAM_ARBITER_STATS_EN
    // Per-requester accept counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_grants <= 32'd0;
            b_grants <= 32'd0;
        end else begin
            a_grants <= a_grants + (grant_a_s ? 32'd1 : 32'd0);
            b_grants <= b_grants + (grant_b_s ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Define BURST_RAM_ARBITER_STATS_EN to also exercise the grant counters.
module tb_burst_ram_arbiter;
    localparam int DW = 4;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_cmd, a_cmd_en, b_cmd, b_cmd_en;
    logic [DW-1:0] a_addr, b_addr;
    logic [63:0]   a_wr_data, b_wr_data;
    logic [7:0]    a_data_mask, b_data_mask;
    logic [63:0]   a_rd_data, b_rd_data;
    logic          a_rd_data_valid, b_rd_data_valid, a_busy, b_busy;
    logic          br_cmd, br_cmd_en;
    logic [DW-1:0] br_addr;
    logic [63:0]   br_wr_data, br_rd_data;
    logic [7:0]    br_data_mask;
    logic          br_rd_data_valid, br_busy;
`ifdef BURST_RAM_ARBITER_STATS_EN
    logic [31:0]   a_grants, b_grants;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    burst_ram_arbiter #(.DEPTH_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_cmd(a_cmd), .a_cmd_en(a_cmd_en), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_data_mask(a_data_mask), .a_rd_data(a_rd_data), .a_rd_data_valid(a_rd_data_valid), .a_busy(a_busy),
        .b_cmd(b_cmd), .b_cmd_en(b_cmd_en), .b_addr(b_addr), .b_wr_data(b_wr_data),
        .b_data_mask(b_data_mask), .b_rd_data(b_rd_data), .b_rd_data_valid(b_rd_data_valid), .b_busy(b_busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
`ifdef BURST_RAM_ARBITER_STATS_EN
        , .a_grants(a_grants), .b_grants(b_grants)
`endif
    );

    // Transaction-level model: who owns the RAM, how many beats are left, and who has tie priority.
    int          m_owner    = 0;   // 0 none, 1 a, 2 b
    bit          m_write    = 1'b0;
    int          m_left     = 0;
    bit          m_prefer_a = 1'b1;
    logic [31:0] m_a_cnt    = 32'd0;
    logic [31:0] m_b_cnt    = 32'd0;
    int          e_grant;
    logic        e_cmd_en, e_cmd, e_a_busy, e_b_busy, e_a_valid, e_b_valid;
    logic [DW-1:0] e_addr;
    logic [63:0] e_wr_data;
    logic [7:0]  e_mask;

    always_comb begin
        e_grant = 0;
        if (rst_n === 1'b1 && m_owner == 0 && !br_busy) begin
            if (a_cmd_en && (!b_cmd_en || m_prefer_a)) e_grant = 1;
            else if (b_cmd_en) e_grant = 2;
        end
        e_cmd_en  = (e_grant != 0);
        e_a_busy  = !rst_n || m_owner != 0 || br_busy || e_grant == 2;
        e_b_busy  = !rst_n || m_owner != 0 || br_busy || e_grant == 1;
        e_a_valid = rst_n && m_owner == 1 && !m_write && br_rd_data_valid;
        e_b_valid = rst_n && m_owner == 2 && !m_write && br_rd_data_valid;
        e_cmd = 1'b0; e_addr = '0; e_wr_data = 64'd0; e_mask = 8'd0;
        if (e_grant == 1) begin
            e_cmd = a_cmd; e_addr = a_addr; e_wr_data = a_wr_data; e_mask = a_data_mask;
        end else if (e_grant == 2) begin
            e_cmd = b_cmd; e_addr = b_addr; e_wr_data = b_wr_data; e_mask = b_data_mask;
        end else if (m_owner == 1 && m_write) begin
            e_wr_data = a_wr_data; e_mask = a_data_mask;
        end else if (m_owner == 2 && m_write) begin
            e_wr_data = b_wr_data; e_mask = b_data_mask;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner <= 0; m_prefer_a <= 1'b1; m_left <= 0;
            m_a_cnt <= 32'd0; m_b_cnt <= 32'd0;
        end else if (e_grant != 0) begin
            m_owner    <= e_grant;
            m_write    <= e_cmd;
            m_left     <= e_cmd ? BC - 1 : BC;
            m_prefer_a <= (e_grant == 2);
            if (e_grant == 1) m_a_cnt <= m_a_cnt + 32'd1;
            else m_b_cnt <= m_b_cnt + 32'd1;
        end else if (m_owner != 0 && (m_write || br_rd_data_valid)) begin
            if (m_left == 1) m_owner <= 0;
            m_left <= m_left - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_beats(input int n);
        for (int k = 0; k < n; k++) begin
            br_rd_data_valid = 1'b1;
            br_rd_data = {$urandom, $urandom};
            tick();
        end
        br_rd_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_cmd_en = 1'b1; b_cmd_en = 1'b1; br_rd_data_valid = 1'b1;
        tick();
        @(negedge clk);
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rst_a_busy got=%b exp=1", a_busy); end
        total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL rst_b_busy got=%b exp=1", b_busy); end
        total++; if (br_cmd_en !== 1'b0) begin bad++; $display("FAIL rst_cmd_en got=%b exp=0", br_cmd_en); end
        total++; if ({a_rd_data_valid, b_rd_data_valid} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", a_rd_data_valid, b_rd_data_valid); end
        tick();
        rst_n = 1'b1; a_cmd_en = 1'b0; b_cmd_en = 1'b0; br_rd_data_valid = 1'b0;
        a_wr_data = 64'hDEAD_BEEF_0000_0001; a_data_mask = 8'hA5;
        @(negedge clk);
        total++; if (br_wr_data !== 64'd0 || br_data_mask !== 8'd0) begin bad++; $display("FAIL idle_wr_zero got=%h/%h exp=0/0", br_wr_data, br_data_mask); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL idle_a_busy got=%b exp=0", a_busy); end
        tick();
    endtask

    task automatic test_single_read();
        int beats = 0;
        int b_beats = 0;
        a_cmd = 1'b0; a_cmd_en = 1'b1; a_addr = 4'd2;
        @(negedge clk);
        total++; if (br_cmd_en !== 1'b1 || br_addr !== 4'd2 || br_cmd !== 1'b0) begin bad++; $display("FAIL rd_accept got en=%b addr=%0d cmd=%b exp en=1 addr=2 cmd=0", br_cmd_en, br_addr, br_cmd); end
        tick();
        a_cmd_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            br_rd_data_valid = (i % 2 == 1);
            br_rd_data = {$urandom, $urandom};
            @(negedge clk);
            if (a_rd_data_valid === 1'b1) begin
                beats++;
                total++; if (a_rd_data !== br_rd_data) begin bad++; $display("FAIL rd_data got=%h exp=%h", a_rd_data, br_rd_data); end
            end
            if (b_rd_data_valid !== 1'b0) b_beats++;
            tick();
        end
        br_rd_data_valid = 1'b0;
        total++; if (beats != BC) begin bad++; $display("FAIL rd_beats got=%0d exp=%0d", beats, BC); end
        total++; if (b_beats != 0) begin bad++; $display("FAIL rd_b_valid got=%0d exp=0", b_beats); end
    endtask

    task automatic test_tie();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        a_cmd = 1'b0; b_cmd = 1'b0; a_addr = 4'd1; b_addr = 4'd3; a_cmd_en = 1'b1; b_cmd_en = 1'b1;
        @(negedge clk);
        total++; if (br_addr !== 4'd1 || a_busy !== 1'b0 || b_busy !== 1'b1) begin bad++; $display("FAIL tie1 got addr=%0d a_busy=%b b_busy=%b exp 1/0/1", br_addr, a_busy, b_busy); end
        tick();
        a_cmd_en = 1'b0;
        for (int k = 0; k < BC; k++) begin
            br_rd_data_valid = 1'b1;
            @(negedge clk);
            total++; if (b_busy !== 1'b1 || a_rd_data_valid !== 1'b1) begin bad++; $display("FAIL tie_burst beat=%0d got b_busy=%b a_valid=%b exp 1/1", k, b_busy, a_rd_data_valid); end
            tick();
        end
        br_rd_data_valid = 1'b0;
        @(negedge clk);
        total++; if (br_cmd_en !== 1'b1 || br_addr !== 4'd3 || b_busy !== 1'b0) begin bad++; $display("FAIL tie_b_next got en=%b addr=%0d b_busy=%b exp 1/3/0", br_cmd_en, br_addr, b_busy); end
        tick();
        b_cmd_en = 1'b0;
        feed_beats(BC);
        a_cmd_en = 1'b1; b_cmd_en = 1'b1;
        @(negedge clk);
        total++; if (br_addr !== 4'd1 || a_busy !== 1'b0 || b_busy !== 1'b1) begin bad++; $display("FAIL tie2 got addr=%0d a_busy=%b b_busy=%b exp 1/0/1", br_addr, a_busy, b_busy); end
        tick();
        a_cmd_en = 1'b0; b_cmd_en = 1'b0;
        feed_beats(BC);
    endtask

    task automatic test_write();
        logic [63:0] exp_d;
        a_cmd = 1'b0; a_addr = 4'd6; a_cmd_en = 1'b1;
        b_cmd = 1'b1; b_addr = 4'd5; b_cmd_en = 1'b1; b_wr_data = 64'h11; b_data_mask = 8'hF0;
        @(negedge clk);
        total++; if (br_cmd_en !== 1'b1 || br_cmd !== 1'b1 || br_addr !== 4'd5 || br_wr_data !== 64'h11 || br_data_mask !== 8'hF0) begin bad++; $display("FAIL wr_accept got en=%b cmd=%b addr=%0d d=%h m=%h", br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask); end
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL wr_a_busy0 got=%b exp=1", a_busy); end
        tick();
        b_cmd_en = 1'b0;
        for (int k = 1; k < BC; k++) begin
            exp_d = 64'((k + 1) * 17);
            b_wr_data = exp_d; b_data_mask = 8'(k);
            @(negedge clk);
            total++; if (br_wr_data !== exp_d || br_data_mask !== 8'(k) || br_cmd_en !== 1'b0) begin bad++; $display("FAIL wr_beat%0d got d=%h m=%h en=%b exp d=%h m=%h en=0", k, br_wr_data, br_data_mask, br_cmd_en, exp_d, 8'(k)); end
            total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL wr_a_busy%0d got=%b exp=1", k, a_busy); end
            tick();
        end
        @(negedge clk);
        total++; if (br_cmd_en !== 1'b1 || a_busy !== 1'b0 || br_addr !== 4'd6) begin bad++; $display("FAIL wr_turnaround got en=%b a_busy=%b addr=%0d exp 1/0/6", br_cmd_en, a_busy, br_addr); end
        tick();
        a_cmd_en = 1'b0;
        feed_beats(BC);
    endtask

    task automatic test_br_busy();
        a_cmd = 1'b0; a_addr = 4'd4; a_cmd_en = 1'b1; br_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (a_busy !== 1'b1 || br_cmd_en !== 1'b0) begin bad++; $display("FAIL brbusy_hold%0d got a_busy=%b en=%b exp 1/0", k, a_busy, br_cmd_en); end
            tick();
        end
        br_busy = 1'b0;
        @(negedge clk);
        total++; if (a_busy !== 1'b0 || br_cmd_en !== 1'b1) begin bad++; $display("FAIL brbusy_release got a_busy=%b en=%b exp 0/1", a_busy, br_cmd_en); end
        tick();
        a_cmd_en = 1'b0;
        feed_beats(BC);
    endtask

    task automatic test_reset_mid();
        a_cmd = 1'b0; a_addr = 4'd7; a_cmd_en = 1'b1;
        tick();
        a_cmd_en = 1'b0;
        feed_beats(2);
        rst_n = 1'b0; br_rd_data_valid = 1'b1; a_cmd_en = 1'b1;
        @(negedge clk);
        total++; if (a_rd_data_valid !== 1'b0 || a_busy !== 1'b1 || br_cmd_en !== 1'b0) begin bad++; $display("FAIL midrst_during got valid=%b a_busy=%b en=%b exp 0/1/0", a_rd_data_valid, a_busy, br_cmd_en); end
        tick();
        rst_n = 1'b1; a_addr = 4'd9;
        @(negedge clk);
        total++; if (a_rd_data_valid !== 1'b0 || br_cmd_en !== 1'b1 || br_addr !== 4'd9 || a_busy !== 1'b0) begin bad++; $display("FAIL midrst_after got valid=%b en=%b addr=%0d a_busy=%b exp 0/1/9/0", a_rd_data_valid, br_cmd_en, br_addr, a_busy); end
        tick();
        a_cmd_en = 1'b0;
        feed_beats(BC);
    endtask

    task automatic test_random();
        bit a_pend = 1'b0;
        bit b_pend = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (!a_pend) begin
                a_cmd_en = ($urandom % 3 == 0); a_cmd = 1'($urandom); a_addr = DW'($urandom);
                a_wr_data = {$urandom, $urandom}; a_data_mask = 8'($urandom);
            end
            if (!b_pend) begin
                b_cmd_en = ($urandom % 3 == 0); b_cmd = 1'($urandom); b_addr = DW'($urandom);
                b_wr_data = {$urandom, $urandom}; b_data_mask = 8'($urandom);
            end
            br_busy = ($urandom % 5 == 0);
            br_rd_data_valid = 1'($urandom);
            br_rd_data = {$urandom, $urandom};
            rst_n = ($urandom % 100 != 0);
            @(negedge clk);
            total++; if (a_busy !== e_a_busy || b_busy !== e_b_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b%b exp=%b%b", i, a_busy, b_busy, e_a_busy, e_b_busy); end
            total++; if (br_cmd_en !== e_cmd_en) begin bad++; $display("FAIL rnd_cmd_en cyc=%0d got=%b exp=%b", i, br_cmd_en, e_cmd_en); end
            total++; if (a_rd_data_valid !== e_a_valid || b_rd_data_valid !== e_b_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b%b exp=%b%b", i, a_rd_data_valid, b_rd_data_valid, e_a_valid, e_b_valid); end
            total++; if (a_rd_data !== br_rd_data || b_rd_data !== br_rd_data) begin bad++; $display("FAIL rnd_fanout cyc=%0d got=%h/%h exp=%h", i, a_rd_data, b_rd_data, br_rd_data); end
            if (rst_n) begin
                total++; if (br_wr_data !== e_wr_data || br_data_mask !== e_mask) begin bad++; $display("FAIL rnd_wr cyc=%0d got=%h/%h exp=%h/%h", i, br_wr_data, br_data_mask, e_wr_data, e_mask); end
            end
            if (e_cmd_en) begin
                total++; if (br_addr !== e_addr || br_cmd !== e_cmd) begin bad++; $display("FAIL rnd_cmd cyc=%0d got=%0d/%b exp=%0d/%b", i, br_addr, br_cmd, e_addr, e_cmd); end
            end
`ifdef BURST_RAM_ARBITER_STATS_EN
            total++; if (a_grants !== m_a_cnt || b_grants !== m_b_cnt) begin bad++; $display("FAIL rnd_grants cyc=%0d got=%0d/%0d exp=%0d/%0d", i, a_grants, b_grants, m_a_cnt, m_b_cnt); end
`endif
            a_pend = a_cmd_en && e_a_busy;
            b_pend = b_cmd_en && e_b_busy;
            tick();
        end
        a_cmd_en = 1'b0; b_cmd_en = 1'b0; br_busy = 1'b0; br_rd_data_valid = 1'b0; rst_n = 1'b1;
    endtask

`ifdef BURST_RAM_ARBITER_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        @(negedge clk);
        total++; if (a_grants !== 32'd0 || b_grants !== 32'd0) begin bad++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", a_grants, b_grants); end
        for (int k = 0; k < 5; k++) begin
            a_cmd = 1'b1; b_cmd = 1'b1;
            if (k % 2 == 0) a_cmd_en = 1'b1; else b_cmd_en = 1'b1;
            tick();
            a_cmd_en = 1'b0; b_cmd_en = 1'b0;
            repeat (BC - 1) tick();
        end
        @(negedge clk);
        total++; if (a_grants !== 32'd3 || b_grants !== 32'd2) begin bad++; $display("FAIL stats_count got=%0d/%0d exp=3/2", a_grants, b_grants); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        @(negedge clk);
        total++; if (a_grants !== 32'd0 || b_grants !== 32'd0) begin bad++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", a_grants, b_grants); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; a_cmd = 1'b0; a_cmd_en = 1'b0; a_addr = '0; a_wr_data = 64'd0; a_data_mask = 8'd0;
        b_cmd = 1'b0; b_cmd_en = 1'b0; b_addr = '0; b_wr_data = 64'd0; b_data_mask = 8'd0;
        br_rd_data = 64'd0; br_rd_data_valid = 1'b0; br_busy = 1'b0;
        tick();
        test_reset();
        test_single_read();
        test_tie();
        test_write();
        test_br_busy();
        test_reset_mid();
        test_random();
`ifdef BURST_RAM_ARBITER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
